// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the asynchronous FIFO (write and read sides).
package fifo_pkg;

  localparam int ADDR_SIZE = 4;

  typedef logic [ADDR_SIZE:0] ptr_t;

  // The helpers work on a 32-bit container. Callers zero-extend narrower
  // pointers and truncate the result; zero upper bits make the conversion
  // identical to a conversion at the pointer's native width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return (bin >> 1) ^ bin;
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = 32'd0;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer, full/almost-full, fill-level and sticky overflow
// generator for the asynchronous FIFO.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE    = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 winc,
  input  logic [ADDR_SIZE:0]   wq2_rptr,
  input  logic                 wclr_ovf,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic [ADDR_SIZE:0]   wptr,
  output logic                 wen,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic [ADDR_SIZE:0]   wlevel,
  output logic                 woverflow
);

  localparam logic [ADDR_SIZE:0] THRESH = (ADDR_SIZE+1)'(AFULL_THRESH);

  logic [ADDR_SIZE:0] wbin_r;
  logic [ADDR_SIZE:0] wptr_r;
  logic               wfull_r;
  logic               walmost_full_r;
  logic [ADDR_SIZE:0] wlevel_r;
  logic               woverflow_r;

  logic [ADDR_SIZE:0] wbin_next_s;
  logic [ADDR_SIZE:0] wgray_next_s;
  logic [ADDR_SIZE:0] rbin_sync_s;
  logic [ADDR_SIZE:0] level_next_s;
  logic [ADDR_SIZE:0] full_ptr_s;
  logic               full_next_s;
  logic               afull_next_s;
  logic               ovf_next_s;
  logic               wen_s;

  // A write reaches memory only when the FIFO is not already full.
  assign wen_s = winc & ~wfull_r;

  // Next-state pointer, level and flag computation from the current
  // synchronized read pointer sample (no assumption of single steps).
  always_comb begin
    wbin_next_s  = wbin_r + (ADDR_SIZE+1)'(wen_s);
    wgray_next_s = (ADDR_SIZE+1)'(bin2gray(32'(wbin_next_s)));
    rbin_sync_s  = (ADDR_SIZE+1)'(gray2bin(32'(wq2_rptr)));
    level_next_s = wbin_next_s - rbin_sync_s;
    // Full: write pointer one lap ahead -> top two Gray bits inverted.
    full_ptr_s   = {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]};
    full_next_s  = (wgray_next_s == full_ptr_s);
    afull_next_s = (level_next_s >= THRESH);
    // Sticky overflow: a rejected write sets it, and set beats clear.
    if (winc && wfull_r) begin
      ovf_next_s = 1'b1;
    end else if (wclr_ovf) begin
      ovf_next_s = 1'b0;
    end else begin
      ovf_next_s = woverflow_r;
    end
  end

  // Register all write-domain state; reset returns everything to empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin_r         <= '0;
      wptr_r         <= '0;
      wfull_r        <= 1'b0;
      walmost_full_r <= 1'b0;
      wlevel_r       <= '0;
      woverflow_r    <= 1'b0;
    end else begin
      wbin_r         <= wbin_next_s;
      wptr_r         <= wgray_next_s;
      wfull_r        <= full_next_s;
      walmost_full_r <= afull_next_s;
      wlevel_r       <= level_next_s;
      woverflow_r    <= ovf_next_s;
    end
  end

  assign waddr        = wbin_r[ADDR_SIZE-1:0];
  assign wptr         = wptr_r;
  assign wen          = wen_s;
  assign wfull        = wfull_r;
  assign walmost_full = walmost_full_r;
  assign wlevel       = wlevel_r;
  assign woverflow    = woverflow_r;

endmodule
